// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: pixel-advance enable in,
// sync, position and frame/line strobes out.
interface vga_sync_gen_if;
   logic       en;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] x;
   logic [9:0] y;
   logic       frame_start;
   logic       line_end;

   modport master (
      input  en,
      output hsync,
      output vsync,
      output video_on,
      output x,
      output y,
      output frame_start,
      output line_end
   );

   modport slave (
      output en,
      input  hsync,
      input  vsync,
      input  video_on,
      input  x,
      input  y,
      input  frame_start,
      input  line_end
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters with
// all outputs registered from the same counter pair.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input logic            clk,
   input logic            reset,
   vga_sync_gen_if.master vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       h_wrap;
   logic       v_wrap;

   logic [9:0] x_q;
   logic [9:0] y_q;
   logic       hsync_q;
   logic       vsync_q;
   logic       video_q;
   logic       fs_q;
   logic       le_q;

   // >= rather than == so a corrupted count still wraps
   assign h_wrap = (h_cnt >= H_LAST);
   assign v_wrap = (v_cnt >= V_LAST);

   always_comb begin
      h_nxt = h_cnt + 10'd1;
      v_nxt = v_cnt;
      if (h_wrap) begin
         h_nxt = '0;
         v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         video_q <= 1'b0;
         fs_q    <= 1'b0;
         le_q    <= 1'b0;
      end else if (vga.en) begin
         h_cnt   <= h_nxt;
         v_cnt   <= v_nxt;
         x_q     <= h_cnt;
         y_q     <= v_cnt;
         video_q <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
         hsync_q <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
         vsync_q <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
         fs_q    <= (h_cnt == '0) && (v_cnt == '0);
         le_q    <= (h_cnt == H_LAST);
      end
   end

   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = video_q;
   assign vga.frame_start = fs_q;
   assign vga.line_end    = le_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance plus a
// narrow-line instance so whole frames fit in a short run.
module tb_vga_sync_gen;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       fs;
      logic       le;
   } vout_t;

   localparam int B_FRAME = 32 * 525;

   logic  clk = 1'b0;
   logic  rst_a;
   logic  rst_b;
   int    checks = 0;
   int    errors = 0;
   longint na = 0;
   longint nb = 0;

   vga_sync_gen_if va ();
   vga_sync_gen_if vb ();

   vga_sync_gen dut_a (
      .clk   (clk),
      .reset (rst_a),
      .vga   (va)
   );

   vga_sync_gen #(
      .H_ACTIVE (16),
      .H_FP     (4),
      .H_SYNC   (6),
      .H_BP     (6)
   ) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .vga   (vb)
   );

   always #5 clk = ~clk;

   // Scoreboard: enabled edges since reset
   always @(posedge clk or negedge rst_a)
      if (!rst_a) na <= 0;
      else if (va.en) na <= na + 1;

   always @(posedge clk or negedge rst_b)
      if (!rst_b) nb <= 0;
      else if (vb.en) nb <= nb + 1;

   // Output after n enabled edges shows raster pixel n-1
   function automatic vout_t ref_out(longint n, int ha, int hf,
                                     int hsw, int hb);
      int     ht = ha + hf + hsw + hb;
      int     vt = 480 + 10 + 2 + 33;
      vout_t  r  = '0;
      longint p;
      int     h;
      int     v;
      r.hs = 1'b1;
      r.vs = 1'b1;
      if (n == 0) return r;
      p    = (n - 1) % longint'(ht * vt);
      h    = int'(p % ht);
      v    = int'(p / ht);
      r.x  = 10'(h);
      r.y  = 10'(v);
      r.vo = (h < ha) && (v < 480);
      r.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
      r.vs = !((v >= 490) && (v < 492));
      r.fs = (h == 0) && (v == 0);
      r.le = (h == ht - 1);
      return r;
   endfunction

   function automatic vout_t exp_a();
      return ref_out(na, 640, 16, 96, 48);
   endfunction

   function automatic vout_t exp_b();
      return ref_out(nb, 16, 4, 6, 6);
   endfunction

   function automatic vout_t got_a();
      return {va.x, va.y, va.hsync, va.vsync,
              va.video_on, va.frame_start, va.line_end};
   endfunction

   function automatic vout_t got_b();
      return {vb.x, vb.y, vb.hsync, vb.vsync,
              vb.video_on, vb.frame_start, vb.line_end};
   endfunction

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @%0t: got %h, expected %h",
                  name, $time, act, req);
      end
   endtask

   initial begin
      int   hs_low;
      int   vs_low;
      int   guard;
      logic [9:0] ynext;

      rst_a = 1'b0;
      rst_b = 1'b0;
      va.en = 1'b0;
      vb.en = 1'b0;

      fork
         forever begin
            @(negedge clk);
            chk("cmp_a", 32'(got_a()), 32'(exp_a()));
            chk("cmp_b", 32'(got_b()), 32'(exp_b()));
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_x", va.x, 0);
      chk("rst_y", va.y, 0);
      chk("rst_hsync", va.hsync, 1);
      chk("rst_vsync", va.vsync, 1);
      chk("rst_video_on", va.video_on, 0);
      chk("rst_frame_start", va.frame_start, 0);
      chk("rst_line_end", va.line_end, 0);

      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_x", va.x, 0);
      chk("hold_fs", va.frame_start, 0);
      chk("hold_vo", va.video_on, 0);

      va.en  = 1'b1;
      vb.en  = 1'b1;
      hs_low = 0;
      vs_low = 0;
      for (int k = 1; k <= B_FRAME + 1; k++) begin
         @(posedge clk);
         #1;
         if (k <= 800 && !va.hsync) hs_low++;
         if (k <= B_FRAME && !vb.vsync) vs_low++;
         case (k)
            1: begin
               chk("e1_x", va.x, 0);
               chk("e1_y", va.y, 0);
               chk("e1_fs", va.frame_start, 1);
               chk("e1_vo", va.video_on, 1);
               chk("e1_hs", va.hsync, 1);
               chk("e1_vs", va.vsync, 1);
            end
            2: begin
               chk("e2_fs", va.frame_start, 0);
               chk("e2_x", va.x, 1);
            end
            640: chk("e640_vo", va.video_on, 1);
            641: chk("e641_vo", va.video_on, 0);
            656: chk("e656_hs", va.hsync, 1);
            657: chk("e657_hs", va.hsync, 0);
            752: chk("e752_hs", va.hsync, 0);
            753: chk("e753_hs", va.hsync, 1);
            799: chk("e799_le", va.line_end, 0);
            800: begin
               chk("e800_le", va.line_end, 1);
               chk("e800_x", va.x, 799);
            end
            801: begin
               chk("e801_x", va.x, 0);
               chk("e801_y", va.y, 1);
               chk("e801_le", va.line_end, 0);
            end
            B_FRAME: begin
               chk("b_last_le", vb.line_end, 1);
               chk("b_last_x", vb.x, 31);
               chk("b_last_y", vb.y, 524);
            end
            B_FRAME + 1: begin
               chk("b_wrap_fs", vb.frame_start, 1);
               chk("b_wrap_x", vb.x, 0);
               chk("b_wrap_y", vb.y, 0);
            end
            default: ;
         endcase
      end
      chk("hsync_low_cycles", hs_low, 96);
      chk("vsync_low_cycles_b", vs_low, 64);

      // Stall on the last pixel of a line
      guard = 0;
      while (exp_a().x != 10'd799 && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("wait_x799_timeout", guard < 2000, 1);
      ynext = (exp_a().y == 10'd524) ? 10'd0 : exp_a().y + 10'd1;
      va.en = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("stall_x", va.x, 799);
         chk("stall_le", va.line_end, 1);
      end
      va.en = 1'b1;
      @(posedge clk);
      #1;
      chk("resume_x", va.x, 0);
      chk("resume_y", va.y, ynext);
      chk("resume_le", va.line_end, 0);

      // Asynchronous reset inside the hsync pulse
      guard = 0;
      while (exp_a().x != 10'd700 && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("wait_x700_timeout", guard < 2000, 1);
      chk("pre_rst_hs", va.hsync, 0);
      #2;
      rst_a = 1'b0;
      #1;
      chk("arst_x", va.x, 0);
      chk("arst_y", va.y, 0);
      chk("arst_hs", va.hsync, 1);
      chk("arst_vs", va.vsync, 1);
      chk("arst_vo", va.video_on, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_x", va.x, 0);
      chk("rel_fs", va.frame_start, 1);
      chk("rel_vo", va.video_on, 1);
      chk("rel_hs", va.hsync, 1);
      @(posedge clk);
      #1;
      chk("rel_x2", va.x, 1);

      // Asynchronous reset in both sync pulses on the narrow instance
      guard = 0;
      while (!(exp_b().x == 10'd20 && exp_b().y == 10'd491)
             && guard < 20000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("wait_b_timeout", guard < 20000, 1);
      chk("b_pre_hs", vb.hsync, 0);
      chk("b_pre_vs", vb.vsync, 0);
      #2;
      rst_b = 1'b0;
      #1;
      chk("b_arst_hs", vb.hsync, 1);
      chk("b_arst_vs", vb.vsync, 1);
      chk("b_arst_x", vb.x, 0);
      chk("b_arst_y", vb.y, 0);
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      chk("b_rel_fs", vb.frame_start, 1);
      chk("b_rel_vo", vb.video_on, 1);
      chk("b_rel_xy", {vb.x, vb.y}, 0);

      repeat (12000) begin
         @(posedge clk);
         #1;
         va.en = ($urandom_range(0, 3) != 0);
         vb.en = ($urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 H_ACTIVE, 640: visible pixels per line.
REQ-002 H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal front porch, sync and back porch widths, in pixels.
REQ-003 V_ACTIVE, 480: visible lines per frame.
REQ-004 V_FP, 10; V_SYNC, 2; V_BP, 33: vertical front porch, sync and back porch widths, in lines.
REQ-005 Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-006 clk  input  1  25 MHz pixel clock from the clock divider; the block's only clock.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 en  input  1  pixel advance enable; when 0, all state holds.
REQ-009 hsync  output  1  horizontal sync, active-low.
REQ-010 vsync  output  1  vertical sync, active-low.
REQ-011 video_on  output  1  1 while the current pixel is in the visible region.
REQ-012 x  output  10  current pixel column.
REQ-013 y  output  10  current pixel row.
REQ-014 frame_start  output  1  single-cycle pulse on the first pixel of each frame.
REQ-015 line_end  output  1  single-cycle pulse on the last pixel of each line.

Function
REQ-016 Internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), each 10 bits wide.
REQ-017 On each rising clk edge with en=1, all outputs register the decode of the current (h_cnt, v_cnt) pair, and the counters then advance.
REQ-018 Output latency is exactly 1 enabled cycle: every output reflects the same (h_cnt, v_cnt) pair, so there is no skew between sync, position and video_on.
REQ-019 h_cnt advance: increments by 1; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
REQ-020 v_cnt advance: increments by 1 only on an h_cnt wrap; at V_TOTAL-1 together with an h_cnt wrap, it wraps to 0.
REQ-021 Output decode:
- x <= h_cnt; y <= v_cnt.
- video_on <= (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync <= 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise 1.
- vsync <= 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise 1.
- frame_start <= (h_cnt==0 && v_cnt==0).
- line_end <= (h_cnt==H_TOTAL-1).
REQ-022 x and y are passed through unmodified outside the visible region (blanking values, up to 799/524); consumers gate them with video_on.
REQ-023 With en=0, counters and all outputs hold their values, including frame_start and line_end, which stay at their last registered value.
REQ-024 Frame period: H_TOTAL*V_TOTAL = 420000 enabled cycles; line period: 800 enabled cycles.
REQ-025 Counters never exceed H_TOTAL-1 or V_TOTAL-1; no out-of-range state is reachable.

Reset
REQ-026 reset=0 immediately forces, without waiting for clk: h_cnt=0, v_cnt=0, x=0, y=0, hsync=1, vsync=1, video_on=0, frame_start=0, line_end=0.
REQ-027 Reset asserted mid-frame abandons the frame; no partial sync pulse is extended past reset assertion.
REQ-028 After reset=1, the first enabled edge presents pixel (0,0): video_on=1, frame_start=1, hsync=1, vsync=1.
REQ-029 Reset release with en=0 leaves the outputs at their reset values until the first enabled edge.

Verification
REQ-030 Reset release, en=1 held -> edge 1: x=0, y=0, frame_start=1, video_on=1; edge 2: frame_start=0, x=1.
REQ-031 Run one line -> hsync low from edge 657 through edge 752 (96 cycles); video_on falls at edge 641; line_end=1 only at edge 800; x returns to 0 and y=1 at edge 801.
REQ-032 Run one full frame -> vsync low for exactly 1600 cycles during y=490..491; frame_start pulses again at edge 420001 with x=0, y=0.
REQ-033 en toggled 1-0-0-1 pattern mid-line -> x advances only on enabled edges; a pulse present when en drops (line_end at x=799) persists until the next enabled edge.
REQ-034 Assert reset asynchronously (between clk edges) at x=700, y=491 -> hsync=1, vsync=1, x=0, y=0 before the next clk edge; normal restart per REQ-028.
REQ-035 Random en over 3 frames -> a scoreboard that counts enabled edges matches x, y, hsync, vsync and video_on exactly, with no count out of range.
